mem_stage_ctrl: RTL and testbench



---
 rtl/mem_stage_ctrl.sv | 143 ++++++++++++++
 tb/tb_mem_stage_ctrl.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage_ctrl.sv
// Memory-stage access controller: runs the req/ack handshake with a multi-cycle
// data memory, stalls the pipeline while an access is in flight, and flags timeouts.
module mem_stage_ctrl #(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 16,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid_in,
    input  logic [1:0]        mem_writeEn,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              mem_req,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ready,
    input  logic              mem_done,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              stall,
    output logic [DATA_W-1:0] rdata,
    output logic              rdata_valid,
    output logic              err
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              wr_q, wr_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              rdataValid_q, rdataValid_d;
    logic              err_q, err_d;

    logic isMemOp;
    logic lastCycle;
    logic finish;
    logic abort;

    assign isMemOp   = valid_in && mem_writeEn[1];
    assign lastCycle = (cnt_q == LAST);

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        wr_d         = wr_q;
        rdata_d      = rdata_q;
        rdataValid_d = 1'b0;
        err_d        = 1'b0;
        finish       = 1'b0;
        abort        = 1'b0;

        case (state_q)
            IDLE: begin
                if (isMemOp) begin
                    addr_d  = addr;
                    wdata_d = wdata;
                    wr_d    = mem_writeEn[0];
                    cnt_d   = '0;
                    state_d = REQ;
                end
            end
            REQ: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (mem_ready && mem_done) begin
                    finish = 1'b1;
                end else if (lastCycle) begin
                    finish = 1'b1;
                    abort  = 1'b1;
                end else if (mem_ready) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (mem_done) begin
                    finish = 1'b1;
                end else if (lastCycle) begin
                    finish = 1'b1;
                    abort  = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Completion beats timeout; an aborted read returns zero to writeback.
        if (finish) begin
            state_d      = DONE;
            err_d        = abort;
            rdataValid_d = !abort && !wr_q;
            if (!wr_q) begin
                rdata_d = abort ? '0 : mem_rdata;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
            wr_q         <= 1'b0;
            rdata_q      <= '0;
            rdataValid_q <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            wr_q         <= wr_d;
            rdata_q      <= rdata_d;
            rdataValid_q <= rdataValid_d;
            err_q        <= err_d;
        end
    end

    // The request is withdrawn for the final budgeted cycle so the abort edge sees it low.
    assign mem_req     = (state_q == REQ) && !lastCycle;
    assign mem_wr      = wr_q;
    assign mem_addr    = addr_q;
    assign mem_wdata   = wdata_q;
    assign stall       = (state_q == REQ) || (state_q == WAIT) ||
                         ((state_q == IDLE) && isMemOp);
    assign rdata       = rdata_q;
    assign rdata_valid = rdataValid_q;
    assign err         = err_q;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Directed bench for mem_stage_ctrl: a default-timeout instance for the handshake
// scenarios and a TIMEOUT=4 instance for the abort and done-at-deadline cases.
module tb_mem_stage_ctrl;

    logic        clk = 1'b0;
    logic        rst;

    logic        validIn;
    logic [1:0]  writeEn;
    logic [15:0] addrIn;
    logic [15:0] wdataIn;
    logic        memReady;
    logic        memDone;
    logic [15:0] memRdata;
    logic        memReq;
    logic        memWr;
    logic [15:0] memAddr;
    logic [15:0] memWdata;
    logic        stallOut;
    logic [15:0] rdataOut;
    logic        rdataValidOut;
    logic        errOut;

    logic        validIn2;
    logic [1:0]  writeEn2;
    logic [15:0] addrIn2;
    logic        memReady2;
    logic        memDone2;
    logic [15:0] memRdata2;
    logic        memReq2;
    logic        memWr2;
    logic [15:0] memAddr2;
    logic [15:0] memWdata2;
    logic        stallOut2;
    logic [15:0] rdataOut2;
    logic        rdataValidOut2;
    logic        errOut2;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mem_stage_ctrl #(.ADDR_W(16), .DATA_W(16), .TIMEOUT(16)) dut (
        .clk(clk), .rst(rst), .valid_in(validIn), .mem_writeEn(writeEn),
        .addr(addrIn), .wdata(wdataIn), .mem_req(memReq), .mem_wr(memWr),
        .mem_addr(memAddr), .mem_wdata(memWdata), .mem_ready(memReady),
        .mem_done(memDone), .mem_rdata(memRdata), .stall(stallOut),
        .rdata(rdataOut), .rdata_valid(rdataValidOut), .err(errOut)
    );

    mem_stage_ctrl #(.ADDR_W(16), .DATA_W(16), .TIMEOUT(4)) dutTo (
        .clk(clk), .rst(rst), .valid_in(validIn2), .mem_writeEn(writeEn2),
        .addr(addrIn2), .wdata(16'h0000), .mem_req(memReq2), .mem_wr(memWr2),
        .mem_addr(memAddr2), .mem_wdata(memWdata2), .mem_ready(memReady2),
        .mem_done(memDone2), .mem_rdata(memRdata2), .stall(stallOut2),
        .rdata(rdataOut2), .rdata_valid(rdataValidOut2), .err(errOut2)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Inputs change 1ns after the edge; outputs are sampled 1ns later, mid-cycle.
    task automatic applyStimulus(input logic v, input logic [1:0] we, input logic [15:0] a,
                                 input logic [15:0] wd, input logic rdy, input logic dn,
                                 input logic [15:0] rd);
        validIn  = v;
        writeEn  = we;
        addrIn   = a;
        wdataIn  = wd;
        memReady = rdy;
        memDone  = dn;
        memRdata = rd;
        #1;
    endtask

    task automatic applyStimulus2(input logic v, input logic [1:0] we, input logic [15:0] a,
                                  input logic rdy, input logic dn, input logic [15:0] rd);
        validIn2  = v;
        writeEn2  = we;
        addrIn2   = a;
        memReady2 = rdy;
        memDone2  = dn;
        memRdata2 = rd;
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1;
        applyStimulus(1'b0, 2'b00, 16'h0, 16'h0, 1'b0, 1'b0, 16'h0);
        applyStimulus2(1'b0, 2'b00, 16'h0, 1'b0, 1'b0, 16'h0);
        cyc();
        cyc();
        rst = 1'b0;
        #1;
        checkOutput("rst_mem_req", 16'(memReq), 16'h0);
        checkOutput("rst_mem_wr", 16'(memWr), 16'h0);
        checkOutput("rst_mem_addr", memAddr, 16'h0);
        checkOutput("rst_mem_wdata", memWdata, 16'h0);
        checkOutput("rst_rdata", rdataOut, 16'h0);
        checkOutput("rst_rdata_valid", 16'(rdataValidOut), 16'h0);
        checkOutput("rst_err", 16'(errOut), 16'h0);
        checkOutput("rst_stall", 16'(stallOut), 16'h0);

        // Load: ready at t+1, done at t+3, DONE at t+4.
        cyc();
        applyStimulus(1'b1, 2'b10, 16'h0040, 16'h0000, 1'b0, 1'b0, 16'h0);
        checkOutput("ld_t_stall", 16'(stallOut), 16'h1);
        checkOutput("ld_t_req", 16'(memReq), 16'h0);
        cyc();
        applyStimulus(1'b0, 2'b00, 16'h0, 16'h0, 1'b1, 1'b0, 16'h0);
        checkOutput("ld_t1_req", 16'(memReq), 16'h1);
        checkOutput("ld_t1_wr", 16'(memWr), 16'h0);
        checkOutput("ld_t1_addr", memAddr, 16'h0040);
        checkOutput("ld_t1_stall", 16'(stallOut), 16'h1);
        cyc();
        applyStimulus(1'b0, 2'b00, 16'h0, 16'h0, 1'b0, 1'b0, 16'h0);
        checkOutput("ld_t2_req", 16'(memReq), 16'h0);
        checkOutput("ld_t2_stall", 16'(stallOut), 16'h1);
        cyc();
        applyStimulus(1'b0, 2'b00, 16'h0, 16'h0, 1'b0, 1'b1, 16'hBEEF);
        checkOutput("ld_t3_stall", 16'(stallOut), 16'h1);
        checkOutput("ld_t3_rvalid", 16'(rdataValidOut), 16'h0);
        cyc();
        applyStimulus(1'b0, 2'b00, 16'h0, 16'h0, 1'b0, 1'b0, 16'h0);
        checkOutput("ld_t4_stall", 16'(stallOut), 16'h0);
        checkOutput("ld_t4_rvalid", 16'(rdataValidOut), 16'h1);
        checkOutput("ld_t4_rdata", rdataOut, 16'hBEEF);
        checkOutput("ld_t4_err", 16'(errOut), 16'h0);
        checkOutput("ld_t4_addr", memAddr, 16'h0040);
        cyc();
        checkOutput("ld_t5_rvalid", 16'(rdataValidOut), 16'h0);
        checkOutput("ld_t5_rdata", rdataOut, 16'hBEEF);

        // Store with ready and done together at t+1.
        applyStimulus(1'b1, 2'b11, 16'h0102, 16'h1234, 1'b0, 1'b0, 16'h0);
        checkOutput("st_t_stall", 16'(stallOut), 16'h1);
        cyc();
        applyStimulus(1'b0, 2'b00, 16'h0, 16'h0, 1'b1, 1'b1, 16'hDEAD);
        checkOutput("st_t1_req", 16'(memReq), 16'h1);
        checkOutput("st_t1_wr", 16'(memWr), 16'h1);
        checkOutput("st_t1_addr", memAddr, 16'h0102);
        checkOutput("st_t1_wdata", memWdata, 16'h1234);
        cyc();
        applyStimulus(1'b0, 2'b00, 16'h0, 16'h0, 1'b0, 1'b0, 16'h0);
        checkOutput("st_t2_req", 16'(memReq), 16'h0);
        checkOutput("st_t2_stall", 16'(stallOut), 16'h0);
        checkOutput("st_t2_rvalid", 16'(rdataValidOut), 16'h0);
        checkOutput("st_t2_rdata", rdataOut, 16'hBEEF);
        checkOutput("st_t2_wr", 16'(memWr), 16'h1);
        cyc();

        // Ready withheld for three cycles, then ready+done together.
        applyStimulus(1'b1, 2'b10, 16'h0200, 16'h0000, 1'b0, 1'b0, 16'h0);
        cyc();
        applyStimulus(1'b0, 2'b00, 16'h0, 16'h0, 1'b0, 1'b0, 16'h0);
        for (int i = 0; i < 3; i++) begin
            checkOutput("hold_req", 16'(memReq), 16'h1);
            checkOutput("hold_addr", memAddr, 16'h0200);
            checkOutput("hold_stall", 16'(stallOut), 16'h1);
            cyc();
        end
        applyStimulus(1'b0, 2'b00, 16'h0, 16'h0, 1'b1, 1'b1, 16'h5A5A);
        checkOutput("hold_t4_req", 16'(memReq), 16'h1);
        checkOutput("hold_t4_stall", 16'(stallOut), 16'h1);
        cyc();
        applyStimulus(1'b0, 2'b00, 16'h0, 16'h0, 1'b0, 1'b0, 16'h0);
        checkOutput("hold_t5_rvalid", 16'(rdataValidOut), 16'h1);
        checkOutput("hold_t5_rdata", rdataOut, 16'h5A5A);
        cyc();

        // ADD, reserved 01, then LD back-to-back with a following LD.
        applyStimulus(1'b1, 2'b00, 16'h0010, 16'h0, 1'b0, 1'b0, 16'h0);
        checkOutput("add_stall", 16'(stallOut), 16'h0);
        cyc();
        applyStimulus(1'b1, 2'b01, 16'h0020, 16'h0, 1'b0, 1'b0, 16'h0);
        checkOutput("rsv_stall", 16'(stallOut), 16'h0);
        checkOutput("rsv_req", 16'(memReq), 16'h0);
        cyc();
        checkOutput("rsv_next_req", 16'(memReq), 16'h0);
        applyStimulus(1'b1, 2'b10, 16'h0300, 16'h0, 1'b0, 1'b0, 16'h0);
        checkOutput("b2b_ld1_stall", 16'(stallOut), 16'h1);
        cyc();
        applyStimulus(1'b1, 2'b10, 16'h0304, 16'h0, 1'b1, 1'b1, 16'h1111);
        checkOutput("b2b_ld1_req", 16'(memReq), 16'h1);
        checkOutput("b2b_ld1_addr", memAddr, 16'h0300);
        cyc();
        applyStimulus(1'b1, 2'b10, 16'h0304, 16'h0, 1'b0, 1'b0, 16'h0);
        checkOutput("b2b_done_stall", 16'(stallOut), 16'h0);
        checkOutput("b2b_done_rdata", rdataOut, 16'h1111);
        checkOutput("b2b_done_req", 16'(memReq), 16'h0);
        cyc();
        checkOutput("b2b_ld2_stall", 16'(stallOut), 16'h1);
        cyc();
        applyStimulus(1'b0, 2'b00, 16'h0, 16'h0, 1'b1, 1'b1, 16'h2222);
        checkOutput("b2b_ld2_req", 16'(memReq), 16'h1);
        checkOutput("b2b_ld2_addr", memAddr, 16'h0304);
        cyc();
        applyStimulus(1'b0, 2'b00, 16'h0, 16'h0, 1'b0, 1'b0, 16'h0);
        checkOutput("b2b_ld2_rdata", rdataOut, 16'h2222);
        cyc();

        // Reset during WAIT, then a stray mem_done.
        applyStimulus(1'b1, 2'b10, 16'h0400, 16'h0, 1'b0, 1'b0, 16'h0);
        cyc();
        applyStimulus(1'b0, 2'b00, 16'h0, 16'h0, 1'b1, 1'b0, 16'h0);
        cyc();
        applyStimulus(1'b0, 2'b00, 16'h0, 16'h0, 1'b0, 1'b0, 16'h0);
        checkOutput("rw_wait_stall", 16'(stallOut), 16'h1);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        applyStimulus(1'b0, 2'b00, 16'h0, 16'h0, 1'b0, 1'b1, 16'h7777);
        checkOutput("rw_stall", 16'(stallOut), 16'h0);
        checkOutput("rw_req", 16'(memReq), 16'h0);
        checkOutput("rw_addr", memAddr, 16'h0);
        checkOutput("rw_rdata", rdataOut, 16'h0);
        cyc();
        applyStimulus(1'b0, 2'b00, 16'h0, 16'h0, 1'b0, 1'b0, 16'h0);
        checkOutput("rw_late_rvalid", 16'(rdataValidOut), 16'h0);
        checkOutput("rw_late_rdata", rdataOut, 16'h0);
        checkOutput("rw_late_err", 16'(errOut), 16'h0);
        checkOutput("rw_late_stall", 16'(stallOut), 16'h0);

        // TIMEOUT=4 instance: a fast read first so rdata is non-zero before the abort.
        applyStimulus2(1'b1, 2'b10, 16'h0500, 1'b0, 1'b0, 16'h0);
        cyc();
        applyStimulus2(1'b0, 2'b00, 16'h0, 1'b1, 1'b1, 16'h9999);
        cyc();
        applyStimulus2(1'b0, 2'b00, 16'h0, 1'b0, 1'b0, 16'h0);
        checkOutput("to_pre_rdata", rdataOut2, 16'h9999);
        cyc();
        applyStimulus2(1'b1, 2'b10, 16'h0600, 1'b0, 1'b0, 16'h0);
        checkOutput("to_t_stall", 16'(stallOut2), 16'h1);
        cyc();
        applyStimulus2(1'b0, 2'b00, 16'h0, 1'b0, 1'b0, 16'h0);
        for (int i = 1; i <= 3; i++) begin
            checkOutput("to_req_high", 16'(memReq2), 16'h1);
            checkOutput("to_err_low", 16'(errOut2), 16'h0);
            cyc();
        end
        checkOutput("to_t4_req", 16'(memReq2), 16'h0);
        checkOutput("to_t4_stall", 16'(stallOut2), 16'h1);
        checkOutput("to_t4_err", 16'(errOut2), 16'h0);
        cyc();
        checkOutput("to_t5_err", 16'(errOut2), 16'h1);
        checkOutput("to_t5_rdata", rdataOut2, 16'h0);
        checkOutput("to_t5_rvalid", 16'(rdataValidOut2), 16'h0);
        checkOutput("to_t5_stall", 16'(stallOut2), 16'h0);
        cyc();
        checkOutput("to_t6_err", 16'(errOut2), 16'h0);
        checkOutput("to_t6_req", 16'(memReq2), 16'h0);

        // mem_done in WAIT on the last budgeted cycle completes instead of aborting.
        applyStimulus2(1'b1, 2'b10, 16'h0700, 1'b0, 1'b0, 16'h0);
        cyc();
        applyStimulus2(1'b0, 2'b00, 16'h0, 1'b1, 1'b0, 16'h0);
        cyc();
        applyStimulus2(1'b0, 2'b00, 16'h0, 1'b0, 1'b0, 16'h0);
        cyc();
        cyc();
        applyStimulus2(1'b0, 2'b00, 16'h0, 1'b0, 1'b1, 16'h4242);
        checkOutput("edge_t4_stall", 16'(stallOut2), 16'h1);
        cyc();
        applyStimulus2(1'b0, 2'b00, 16'h0, 1'b0, 1'b0, 16'h0);
        checkOutput("edge_t5_err", 16'(errOut2), 16'h0);
        checkOutput("edge_t5_rvalid", 16'(rdataValidOut2), 16'h1);
        checkOutput("edge_t5_rdata", rdataOut2, 16'h4242);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
